fpu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one floating-point ALU (16-bit and 32-bit modes) between two independent requesters. Each requester submits a complete operation (mode, operands, op code, rounding mode) over a valid/ready handshake. The arbiter issues the operation to the ALU with a one-cycle start pulse, waits for done, and returns the result and flags over a per-requester response handshake. It sits between the operand-entry front end (switch console or test-pattern source) and the FP ALU.

---
 rtl/fpu_share_arbiter_pkg.sv | 24 ++
 rtl/fpu_share_arbiter_if.sv | 44 ++++
 rtl/fpu_share_arbiter_rr.sv | 14 +
 rtl/fpu_share_arbiter.sv | 116 +++++++++++
 tb/tb_fpu_share_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_share_arbiter_pkg.sv
// fpu_arb_pkg: FSM encoding, op codes and flag layout shared by the FP ALU share arbiter.
package fpu_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // A forced completion reports itself as an invalid operation.
    localparam logic [4:0] FLAG_TIMEOUT = 5'b10000;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fpu_share_arbiter_if.sv
// fpu_share_arbiter_if: request/response handshakes plus the ALU issue/result bus.
interface fpu_share_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_mode;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_op;
    logic [1:0]  req_round;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        busy;
    logic        alu_start;
    logic        alu_mode_fp;
    logic [1:0]  alu_op;
    logic        alu_round;
    logic [15:0] alu_a16;
    logic [15:0] alu_b16;
    logic [31:0] alu_a32;
    logic [31:0] alu_b32;
    logic        alu_done;
    logic [15:0] alu_r16;
    logic [31:0] alu_r32;
    logic [4:0]  alu_f16;
    logic [4:0]  alu_f32;

    modport slave (
        input  req_valid, req_mode, req_a, req_b, req_op, req_round, rsp_ready,
               alu_done, alu_r16, alu_r32, alu_f16, alu_f32,
        output req_ready, rsp_valid, rsp_data, rsp_flags, busy, alu_start,
               alu_mode_fp, alu_op, alu_round, alu_a16, alu_b16, alu_a32, alu_b32
    );

    modport master (
        output req_valid, req_mode, req_a, req_b, req_op, req_round, rsp_ready,
               alu_done, alu_r16, alu_r32, alu_f16, alu_f32,
        input  req_ready, rsp_valid, rsp_data, rsp_flags, busy, alu_start,
               alu_mode_fp, alu_op, alu_round, alu_a16, alu_b16, alu_a32, alu_b32
    );

endinterface

// File: rtl/fpu_share_arbiter_rr.sv
// rr_arbiter2: combinational two-way round-robin grant; the requester other than i_last wins a tie.
module rr_arbiter2
    import fpu_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant,
    output logic       o_idx
);

    assign o_idx   = &i_req ? ~i_last : i_req[1];
    assign o_grant = |i_req ? onehot2(o_idx) : 2'b00;

endmodule

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: shares one FP ALU between two requesters (IDLE/ISSUE/WAIT/RESP sequencer).
// Define FPU_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYCLES WAIT cycles without alu_done.
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic               clk,
    input logic               reset,
    fpu_share_arbiter_if.slave bus
);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_g;
    logic        r_mode;
    logic        r_round;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_data;
    logic [4:0]  r_flags;
    logic [1:0]  w_grant;
    logic        w_idx;
    logic        w_accept;
    logic        w_done;
    logic        w_timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    rr_arbiter2 u_arb (
        .i_req   (bus.req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    // Counter sits at zero outside WAIT, so it is already clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else r_cnt <= r_state == WAIT ? r_cnt + 1'b1 : '0;
    end
    assign w_timeout = r_state == WAIT && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_accept = r_state == IDLE && |bus.req_valid;
    assign w_done   = r_state == WAIT && (bus.alu_done || w_timeout);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = |bus.req_valid ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_done ? RESP : WAIT;
            RESP:    w_next = bus.rsp_ready[r_g] ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_g     <= 1'b0;
            r_mode  <= 1'b0;
            r_round <= 1'b0;
            r_op    <= 2'b00;
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            r_data  <= 32'h0;
            r_flags <= 5'h0;
        end else begin
            if (w_accept) begin
                r_g     <= w_idx;
                r_mode  <= bus.req_mode[w_idx];
                r_round <= bus.req_round[w_idx];
                r_op    <= w_idx ? bus.req_op[3:2] : bus.req_op[1:0];
                r_a     <= w_idx ? bus.req_a[63:32] : bus.req_a[31:0];
                r_b     <= w_idx ? bus.req_b[63:32] : bus.req_b[31:0];
            end
            // A real done in the limit cycle takes precedence over the timeout.
            if (w_done) begin
                r_data  <= bus.alu_done ? (r_mode ? bus.alu_r32 : {16'h0, bus.alu_r16}) : 32'h0;
                r_flags <= bus.alu_done ? (r_mode ? bus.alu_f32 : bus.alu_f16) : FLAG_TIMEOUT;
            end
            if (r_state == RESP && bus.rsp_ready[r_g]) r_last <= r_g;
        end
    end

    assign bus.req_ready   = r_state == IDLE ? w_grant : 2'b00;
    assign bus.rsp_valid   = r_state == RESP ? onehot2(r_g) : 2'b00;
    assign bus.rsp_data    = r_data;
    assign bus.rsp_flags   = r_flags;
    assign bus.busy        = r_state != IDLE;
    assign bus.alu_start   = r_state == ISSUE;
    assign bus.alu_mode_fp = r_mode;
    assign bus.alu_op      = r_op;
    assign bus.alu_round   = r_round;
    assign bus.alu_a16     = r_mode ? 16'h0 : r_a[15:0];
    assign bus.alu_b16     = r_mode ? 16'h0 : r_b[15:0];
    assign bus.alu_a32     = r_mode ? r_a : 32'h0;
    assign bus.alu_b32     = r_mode ? r_b : 32'h0;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: vector table plus handshake/reset/timeout sequences with a response scoreboard.
module tb_fpu_share_arbiter;

    logic clk;
    logic reset;
    fpu_share_arbiter_if bus ();

    fpu_share_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        g;
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        rnd;
        int          lat;
        logic [15:0] r16;
        logic [31:0] r32;
        logic [4:0]  f16;
        logic [4:0]  f32;
        logic [31:0] exp_data;
        logic [4:0]  exp_flags;
        int          hold;
    } vec_t;

    typedef struct {
        logic        g;
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    logic        m_en = 1'b0;
    int          m_lat = 1;
    logic        m_done = 1'b0;
    logic        t_done = 1'b0;
    logic [15:0] m_r16 = '0;
    logic [31:0] m_r32 = '0;
    logic [4:0]  m_f16 = '0;
    logic [4:0]  m_f32 = '0;

    assign bus.alu_done = m_done | t_done;
    assign bus.alu_r16  = m_r16;
    assign bus.alu_r32  = m_r32;
    assign bus.alu_f16  = m_f16;
    assign bus.alu_f32  = m_f32;

    // ALU model: done pulses m_lat cycles after the start pulse is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (m_en && bus.alu_start) begin
                repeat (m_lat) @(negedge clk);
                m_done = 1'b1;
                @(negedge clk);
                m_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [1:0] ohe(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: response with empty scoreboard, got data %0h", name, bus.rsp_data);
        end else begin
            e = sb.pop_front();
            chk({name, "_valid"}, bus.rsp_valid, ohe(e.g));
            chk({name, "_data"}, bus.rsp_data, e.data);
            chk({name, "_flags"}, bus.rsp_flags, e.flags);
        end
    endtask

    task automatic drive_req(input logic g, input logic mode, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] op, input logic rnd);
        bus.req_mode[g]  = mode;
        bus.req_round[g] = rnd;
        if (g) begin
            bus.req_a[63:32] = a;
            bus.req_b[63:32] = b;
            bus.req_op[3:2]  = op;
        end else begin
            bus.req_a[31:0] = a;
            bus.req_b[31:0] = b;
            bus.req_op[1:0] = op;
        end
        bus.req_valid[g] = 1'b1;
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (bus.rsp_valid == 2'b00 && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int t;
        int lat;
        logic [31:0] hd;
        string nm;
        nm = $sformatf("v%0d", k);
        m_en = 1'b1;
        m_lat = v.lat;
        m_r16 = v.r16;
        m_r32 = v.r32;
        m_f16 = v.f16;
        m_f32 = v.f32;
        drive_req(v.g, v.mode, v.a, v.b, v.op, v.rnd);
        t = 0;
        while (!bus.req_ready[v.g] && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({nm, "_ready"}, bus.req_ready, ohe(v.g));
        sb.push_back('{v.g, v.exp_data, v.exp_flags});
        @(negedge clk);
        bus.req_valid[v.g] = 1'b0;
        #1;
        chk({nm, "_start"}, bus.alu_start, 1);
        chk({nm, "_ctl"}, {bus.alu_mode_fp, bus.alu_op, bus.alu_round}, {v.mode, v.op, v.rnd});
        chk({nm, "_op16"}, {bus.alu_a16, bus.alu_b16}, v.mode ? 32'h0 : {v.a[15:0], v.b[15:0]});
        chk({nm, "_op32"}, {bus.alu_a32, bus.alu_b32}, v.mode ? {v.a, v.b} : 64'h0);
        wait_rsp(lat);
        chk({nm, "_latency"}, lat, v.lat + 2);
        hd = bus.rsp_data;
        if (v.hold > 0) begin
            bus.req_valid[!v.g] = 1'b1;
            bus.rsp_ready[!v.g] = 1'b1;
            repeat (v.hold) begin
                @(negedge clk);
                #1;
            end
            chk({nm, "_hold_data"}, bus.rsp_data, hd);
            chk({nm, "_hold_state"}, {bus.busy, bus.req_ready, bus.rsp_valid}, {1'b1, 2'b00, ohe(v.g)});
            bus.req_valid[!v.g] = 1'b0;
            bus.rsp_ready[!v.g] = 1'b0;
        end
        bus.rsp_ready[v.g] = 1'b1;
        pop_check(nm);
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        #1;
        chk({nm, "_idle"}, {bus.busy, bus.rsp_valid}, 3'b000);
    endtask

    vec_t vecs[5];

    initial begin
        int lat;
        int cyc;
        int prev;
        int n_acc;
        int n_rsp;
        logic both;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_3C00, 32'h0000_4000, 2'b00, 1'b0, 2,
                    16'h4200, 32'hDEAD_BEEF, 5'b00000, 5'b11111, 32'h0000_4200, 5'b00000, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 2'b10, 1'b1, 2,
                    16'h1234, 32'h4000_0000, 5'b11111, 5'b00000, 32'h4000_0000, 5'b00000, 5};
        vecs[2] = '{1'b0, 1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 2'b10, 1'b0, 1,
                    16'h0000, 32'h7F80_0000, 5'b00000, 5'b00101, 32'h7F80_0000, 5'b00101, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_3C00, 32'h0000_0000, 2'b11, 1'b1, 5,
                    16'h7C00, 32'h0000_0000, 5'b01000, 5'b00010, 32'h0000_7C00, 5'b01000, 2};
        vecs[4] = '{1'b0, 1'b0, 32'hABCD_3C00, 32'h1234_BC00, 2'b01, 1'b1, 3,
                    16'h0001, 32'hFFFF_FFFF, 5'b00001, 5'b11111, 32'h0000_0001, 5'b00001, 0};
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_mode = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.req_round = '0;
        bus.rsp_ready = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp", {bus.rsp_data, bus.rsp_flags, bus.rsp_valid, bus.req_ready, bus.busy, bus.alu_start}, 0);
        chk("reset_alu_ctl", {bus.alu_mode_fp, bus.alu_op, bus.alu_round, bus.alu_a16, bus.alu_b16}, 0);
        chk("reset_alu_op32", {bus.alu_a32, bus.alu_b32}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        m_en = 1'b0;
        m_r16 = 16'h4400;
        m_f16 = 5'b00000;
        @(negedge clk);
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        #1;
        chk("spur_idle", {bus.busy, bus.rsp_valid, bus.alu_start}, 0);
        drive_req(1'b0, 1'b0, 32'h4000, 32'h4000, 2'b10, 1'b0);
        chk("spur_ready", bus.req_ready, 2'b01);
        sb.push_back('{1'b0, 32'h0000_4400, 5'b00000});
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("spur_issue", bus.alu_start, 1);
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        #1;
        chk("spur_wait_entry", {bus.busy, bus.alu_start, bus.rsp_valid}, 4'b1000);
        repeat (3) @(negedge clk);
        #1;
        chk("spur_still_wait", {bus.busy, bus.rsp_valid}, 3'b100);
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        #1;
        bus.rsp_ready[0] = 1'b1;
        pop_check("spur_rsp");
        @(negedge clk);
        bus.rsp_ready = 2'b00;

        drive_req(1'b1, 1'b1, 32'h4049_0FDB, 32'hC000_0000, 2'b11, 1'b1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_rsp", {bus.rsp_data, bus.rsp_flags, bus.rsp_valid, bus.req_ready, bus.busy, bus.alu_start}, 0);
        chk("rst_async_alu_ctl", {bus.alu_mode_fp, bus.alu_op, bus.alu_round, bus.alu_a16, bus.alu_b16}, 0);
        chk("rst_async_alu_op32", {bus.alu_a32, bus.alu_b32}, 0);
        @(negedge clk);
        reset = 1'b0;
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_late_done", {bus.busy, bus.rsp_valid}, 3'b000);

        m_en = 1'b1;
        m_lat = 1;
        m_r16 = 16'h1111;
        m_r32 = 32'h2222_2222;
        m_f16 = 5'b00010;
        m_f32 = 5'b00100;
        bus.req_mode = 2'b10;
        bus.req_a = {32'h0000_0002, 32'h0000_0001};
        bus.req_b = {32'h0000_0003, 32'h0000_0004};
        bus.req_op = 4'b0100;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        cyc = 0;
        prev = 0;
        n_acc = 0;
        n_rsp = 0;
        both = 1'b0;
        while (n_rsp < 4 && cyc < 100) begin
            if (bus.req_ready == 2'b11) both = 1'b1;
            if (|(bus.req_valid & bus.req_ready)) begin
                chk($sformatf("rr_grant%0d", n_acc), bus.req_ready, ohe(n_acc[0]));
                if (n_acc > 0) chk($sformatf("rr_gap%0d", n_acc), cyc - prev, 4);
                prev = cyc;
                sb.push_back(n_acc[0] ? '{1'b1, 32'h2222_2222, 5'b00100} : '{1'b0, 32'h0000_1111, 5'b00010});
                n_acc++;
            end
            if (|(bus.rsp_valid & bus.rsp_ready)) begin
                pop_check($sformatf("rr_rsp%0d", n_rsp));
                n_rsp++;
            end
            if (n_rsp < 4) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        bus.req_valid = 2'b00;
        chk("rr_count", n_rsp, 4);
        chk("rr_never_both", both, 0);
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        sb.delete();

        m_en = 1'b0;
        m_r32 = 32'h4248_0000;
        m_f32 = 5'b00001;
`ifdef FPU_ARB_TIMEOUT_EN
        drive_req(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 1'b0);
        sb.push_back('{1'b1, 32'h0, 5'b10000});
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        wait_rsp(lat);
        chk("to_latency", lat, 10);
        bus.rsp_ready[1] = 1'b1;
        pop_check("to_rsp");
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        drive_req(1'b0, 1'b1, 32'h4120_0000, 32'h40A0_0000, 2'b10, 1'b1);
        sb.push_back('{1'b0, 32'h4248_0000, 5'b00001});
        repeat (9) @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("to_edge_pending", bus.rsp_valid, 0);
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        #1;
        bus.rsp_ready[0] = 1'b1;
        pop_check("to_edge_rsp");
        @(negedge clk);
        bus.rsp_ready = 2'b00;
`else
        drive_req(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 1'b0);
        sb.push_back('{1'b1, 32'h4248_0000, 5'b00001});
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (20) @(negedge clk);
        #1;
        chk("nto_still_wait", {bus.busy, bus.rsp_valid}, 3'b100);
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        #1;
        bus.rsp_ready[1] = 1'b1;
        pop_check("nto_rsp");
        @(negedge clk);
        bus.rsp_ready = 2'b00;
`endif
        #1;
        chk("final_idle", {bus.busy, bus.rsp_valid}, 3'b000);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
